// File: rtl/uart_alu_pkg.sv
// Shared types and default parameters for the UART/ALU byte controller.
package uart_alu_pkg;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_NB_OP   = 6;
    localparam int DEF_TIMEOUT = 1000000;
    localparam int DEF_TO_BIT  = 20;

    // Controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/uart_alu_interface_if.sv
// UART-side and ALU-side signal bundle of the byte controller.
interface uart_alu_if
    import uart_alu_pkg::*;
#(
    parameter int DBIT  = DEF_DBIT,
    parameter int NB_OP = DEF_NB_OP
);
    logic             rx_done;
    logic [DBIT-1:0]  rx_data;
    logic             tx_done;
    logic             tx_start;
    logic [DBIT-1:0]  tx_data;
    logic [DBIT-1:0]  alu_a;
    logic [DBIT-1:0]  alu_b;
    logic [NB_OP-1:0] alu_op;
    logic [DBIT-1:0]  alu_result;

    // Controller side: consumes UART events and ALU result, drives operands and transmit.
    modport master (
        input  rx_done, rx_data, tx_done, alu_result,
        output tx_start, tx_data, alu_a, alu_b, alu_op
    );

    // UART/ALU side: the mirror image.
    modport slave (
        output rx_done, rx_data, tx_done, alu_result,
        input  tx_start, tx_data, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/uart_alu_interface_timer.sv
// Inter-byte watchdog: counts while run is high, pulses expired on the
// cycle the count reaches TIMEOUT-1. TIMEOUT==0 disables expiry entirely.
module inter_byte_timer #(
    parameter int TIMEOUT = 1000000,
    parameter int TO_BIT  = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam bit              ENABLED = (TIMEOUT != 0);
    localparam logic [TO_BIT-1:0] LAST  = ENABLED ? TO_BIT'(TIMEOUT - 1) : '0;

    logic [TO_BIT-1:0] count;

    // Counter: held at zero when idle or cleared, otherwise advances.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || !run) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Expiry decode, only meaningful while running.
    always_comb begin
        expired = ENABLED && run && (count == LAST);
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Sequences three received bytes (A, B, opcode) into the ALU, captures the
// result and launches a one-byte transmit, with an inter-byte timeout.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int NB_OP   = DEF_NB_OP,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_BIT  = DEF_TO_BIT
) (
    input  logic          clk,
    input  logic          reset,
    uart_alu_if.master    bus,
    output logic          busy,
    output logic          overrun_tick,
    output logic          timeout_tick
);
    state_t           state;
    logic [DBIT-1:0]  alu_a;
    logic [DBIT-1:0]  alu_b;
    logic [NB_OP-1:0] alu_op;
    logic [DBIT-1:0]  tx_data;
    logic             timer_run;
    logic             timer_clear;
    logic             expired;

    // Timer runs only while a frame is partially received.
    always_comb begin
        timer_run   = (state == WAIT_B) || (state == WAIT_OP);
        timer_clear = bus.rx_done || expired;
    end

    inter_byte_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_BIT  (TO_BIT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (timer_run),
        .clear   (timer_clear),
        .expired (expired)
    );

    // Frame sequencer with registered operands, result and event pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= WAIT_A;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            tx_data      <= '0;
            overrun_tick <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            overrun_tick <= 1'b0;
            timeout_tick <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (bus.rx_done) begin
                        alu_a <= bus.rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A byte on the expiry cycle wins over the timeout.
                    if (bus.rx_done) begin
                        alu_b <= bus.rx_data;
                        state <= WAIT_OP;
                    end else if (expired) begin
                        timeout_tick <= 1'b1;
                        state        <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (bus.rx_done) begin
                        alu_op <= bus.rx_data[NB_OP-1:0];
                        state  <= EXEC;
                    end else if (expired) begin
                        timeout_tick <= 1'b1;
                        state        <= WAIT_A;
                    end
                end
                EXEC: begin
                    tx_data      <= bus.alu_result;
                    overrun_tick <= bus.rx_done;
                    state        <= SEND;
                end
                SEND: begin
                    overrun_tick <= bus.rx_done;
                    state        <= WAIT_TX;
                end
                WAIT_TX: begin
                    overrun_tick <= bus.rx_done;
                    if (bus.tx_done) begin
                        state <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

    // Outputs are registers or pure state decodes.
    assign bus.alu_a    = alu_a;
    assign bus.alu_b    = alu_b;
    assign bus.alu_op   = alu_op;
    assign bus.tx_data  = tx_data;
    assign bus.tx_start = (state == SEND);
    assign busy         = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
Byte-level controller that sequences the UART datapath for the ALU exercise. It collects three received bytes (operand A, operand B, opcode) from the UART receiver and drives them to the ALU. It then captures the ALU result and launches a single-byte transmit through the UART transmitter. It sits between the uart top (rx_done/rd_data, tx_start/tx_data/tx_done) and the combinational ALU, and guards against stalled frames with an inter-byte timeout.

Parameters:
DBIT, 8, data/operand/result width in bits (matches UART data bits)
NB_OP, 6, opcode width; taken from rx_data[NB_OP-1:0]
TIMEOUT, 1000000, clock cycles allowed between bytes of one frame; 0 disables the timeout
TO_BIT, 20, timeout counter width; must satisfy 2^TO_BIT > TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low: reset==0 at a clk edge resets the block
rx_done  in  1  one-cycle pulse from UART rx; rx_data valid this cycle
rx_data  in  DBIT  received byte
tx_done  in  1  one-cycle pulse from UART tx at end of stop bit
tx_start  out  1  one-cycle pulse requesting transmission of tx_data
tx_data  out  DBIT  byte to transmit (registered)
alu_a  out  DBIT  operand A register
alu_b  out  DBIT  operand B register
alu_op  out  NB_OP  opcode register
alu_result  in  DBIT  combinational ALU output
busy  out  1  high in EXEC, SEND, WAIT_TX
overrun_tick  out  1  one-cycle pulse: byte received while busy (byte dropped)
timeout_tick  out  1  one-cycle pulse: frame abandoned by timeout

Behaviour:
- Reset (reset==0 at edge): state=WAIT_A; alu_a, alu_b, alu_op, tx_data, timer = 0; tx_start, overrun_tick, timeout_tick = 0; busy=0. Reset wins over every other event, including mid-frame and mid-transmit. A transmit already in flight in the UART is not aborted; a tx_done arriving after reset is ignored.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: rx_done -> alu_a<=rx_data, go to WAIT_B, timer<=0. No timeout runs here.
- WAIT_B: rx_done -> alu_b<=rx_data, go to WAIT_OP, timer<=0.
- WAIT_OP: rx_done -> alu_op<=rx_data[NB_OP-1:0], go to EXEC. Upper rx_data bits are ignored.
- EXEC (exactly 1 cycle): tx_data<=alu_result; go to SEND.
- SEND (exactly 1 cycle): tx_start=1 (decoded from state, high only here); go to WAIT_TX.
- WAIT_TX: tx_done -> go to WAIT_A. Waits indefinitely; there is no timeout.
- Latency: opcode rx_done in cycle T -> EXEC in T+1 (result captured at end of T+1) -> tx_start high in T+2 only.
- Timer: increments each cycle in WAIT_B/WAIT_OP; holds 0 in all other states.
  - Timer reaching TIMEOUT-1 with no rx_done that cycle -> timeout_tick=1 for one cycle, go to WAIT_A, timer<=0.
  - rx_done in the same cycle as expiry: the byte is accepted and no timeout occurs.
- alu_a/alu_b/alu_op hold their last latched values across timeouts and frames; only reset clears them.
- rx_done in EXEC/SEND/WAIT_TX: byte dropped, overrun_tick=1 that cycle, state unaffected.
- tx_done outside WAIT_TX: ignored.
- tx_data is stable from EXEC+1 until the next EXEC.
- All outputs are registered or pure state decodes; there are no combinational paths from inputs to outputs.

Decomposition:
- Package uart_alu_pkg holds:
  - state encoding localparams (3-bit);
  - default DBIT/NB_OP/TIMEOUT constants shared with the top-level wrapper and the bench.
- One sub-module, inter_byte_timer. Parameters TIMEOUT, TO_BIT; inputs clk, reset, run, clear; output expired pulse. It contains the counter and the TIMEOUT==0 disable logic.

Test Plan:
- Basic frame: rx bytes 0x05, 0x03, 0x20 with a bench ALU model (0x20=ADD) -> alu_a=0x05, alu_b=0x03, alu_op=0x20; tx_data=0x08; tx_start pulses exactly once, 2 cycles after the opcode rx_done. After tx_done, state returns to WAIT_A with busy=0.
- Opcode masking: opcode byte 0xE2 -> alu_op=0x22. Back-to-back second frame 0xFF, 0x01, 0x20 -> tx_data=0x00 (8-bit wrap).
- Timeout: TIMEOUT=100; send A=0x11, then nothing -> timeout_tick pulses 100 cycles after entering WAIT_B. A subsequent frame 0x02, 0x02, 0x20 yields tx_data=0x04. A byte arriving on the exact expiry cycle is accepted and no timeout_tick occurs.
- Overrun: inject rx_done with 0xAA during WAIT_TX -> overrun_tick=1 for 1 cycle, alu_a unchanged; the next frame after tx_done is processed normally.
- Reset mid-frame: reset=0 for one edge while in WAIT_OP -> all outputs 0, state WAIT_A. A stray tx_done after reset produces no tx_start.
- TIMEOUT=0: wait 2,000,000 cycles between bytes -> no timeout_tick; the frame completes with the correct result.
